// File: rtl/puzzle_run_pkg.sv
// Shared definitions for the puzzle run controller: FSM states and frame sizing.
package puzzle_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_SETTLE,
    ST_CAPTURE,
    ST_STREAM
  } run_state_e;

  // Bytes in one output frame: all result words followed by the cycle count.
  function automatic int frame_bytes(input int n_results, input int result_width,
                                     input int cycle_width);
    return n_results * result_width / 8 + cycle_width / 8;
  endfunction

  function automatic int byte_idx_width(input int n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

  localparam int DEFAULT_FRAME_BYTES = frame_bytes(2, 64, 32);
  localparam int DEFAULT_BYTE_IDX_W  = byte_idx_width(DEFAULT_FRAME_BYTES);

endpackage

// File: rtl/result_byte_serializer.sv
// Holds the captured results plus cycle count and streams them LSB-first as a
// byte frame over a valid/ready link.
module result_byte_serializer
  import puzzle_run_pkg::*;
#(
  parameter int N_RESULTS    = 2,
  parameter int RESULT_WIDTH = 64,
  parameter int CYCLE_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_i,
  input  logic [N_RESULTS*RESULT_WIDTH-1:0] results_i,
  input  logic [CYCLE_WIDTH-1:0]            count_i,
  output logic [7:0]                        out_data_o,
  output logic                              out_valid_o,
  output logic                              out_last_o,
  input  logic                              out_ready_i,
  output logic                              frame_done_o
);

  localparam int B       = frame_bytes(N_RESULTS, RESULT_WIDTH, CYCLE_WIDTH);
  localparam int IDX_W   = byte_idx_width(B);
  localparam int FRAME_W = 8 * B;

  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] load_frame;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_next;
  logic [7:0]         out_data_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic               xfer;

  assign load_frame = {count_i, results_i};
  assign idx_next   = idx_q + 1'b1;
  assign xfer       = out_valid_q && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: frame storage is reset along with control so a discarded frame
    // never leaks onto out_data after an asynchronous reset.
    if (!rst_n) begin
      frame_q     <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (load_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      frame_q     <= load_frame;
      idx_q       <= '0;
      out_data_q  <= load_frame[7:0];
      out_valid_q <= 1'b1;
      out_last_q  <= (B == 1);
    end else if (xfer) begin
      if (out_last_q) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        idx_q      <= idx_next;
        out_data_q <= frame_q[8*int'(idx_next) +: 8];
        out_last_q <= (int'(idx_next) == B - 1);
      end
    end
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign out_last_o   = out_last_q;
  assign frame_done_o = xfer && out_last_q;

endmodule

// File: rtl/puzzle_run_controller.sv
// Run controller for a dayNN solver core: reset hold, timed run, settle,
// result capture and byte-stream readout of results plus cycle count.
module puzzle_run_controller
  import puzzle_run_pkg::*;
#(
  parameter int N_RESULTS     = 2,
  parameter int RESULT_WIDTH  = 64,
  parameter int CYCLE_WIDTH   = 32,
  parameter int RESET_HOLD    = 5,
  parameter int SETTLE_CYCLES = 5,
  parameter int TIMEOUT       = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              core_rst,
  input  logic                              core_done,
  input  logic [N_RESULTS*RESULT_WIDTH-1:0] core_results,
  output logic                              busy,
  output logic [CYCLE_WIDTH-1:0]            cycle_count,
  output logic                              results_valid,
  output logic                              timed_out,
  output logic [7:0]                        out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last
);

  localparam int WAIT_MAX = (RESET_HOLD > SETTLE_CYCLES) ? RESET_HOLD : SETTLE_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  run_state_e             state_q, state_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [CYCLE_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d, count_inc;
  logic                   timed_out_q, timed_out_d;
  logic                   results_valid_q, results_valid_d;
  logic                   core_rst_q, core_rst_d;
  logic                   capture;
  logic                   frame_done;

  assign count_inc = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CYCLE_WIDTH'(1);
  assign capture   = (state_q == ST_CAPTURE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    cycle_cnt_d     = cycle_cnt_q;
    timed_out_d     = timed_out_q;
    results_valid_d = results_valid_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        cycle_cnt_d     = '0;
        results_valid_d = 1'b0;
        timed_out_d     = 1'b0;
        wait_cnt_d      = '0;
        state_d         = ST_HOLD;
      end
      ST_HOLD: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == WAIT_W'(RESET_HOLD - 1)) begin
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_done) begin
          wait_cnt_d = '0;
          state_d    = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
        end else begin
          cycle_cnt_d = count_inc;
          if (TIMEOUT != 0 && count_inc == CYCLE_WIDTH'(TIMEOUT)) begin
            timed_out_d = 1'b1;
            state_d     = ST_CAPTURE;
          end
        end
      end
      // core_done is deliberately not looked at while settling.
      ST_SETTLE: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == WAIT_W'(SETTLE_CYCLES - 1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        results_valid_d = 1'b1;
        state_d         = ST_STREAM;
      end
      ST_STREAM: if (frame_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    core_rst_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      wait_cnt_q      <= '0;
      cycle_cnt_q     <= '0;
      timed_out_q     <= 1'b0;
      results_valid_q <= 1'b0;
      core_rst_q      <= 1'b1;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      cycle_cnt_q     <= cycle_cnt_d;
      timed_out_q     <= timed_out_d;
      results_valid_q <= results_valid_d;
      core_rst_q      <= core_rst_d;
    end
  end

  result_byte_serializer #(
    .N_RESULTS   (N_RESULTS),
    .RESULT_WIDTH(RESULT_WIDTH),
    .CYCLE_WIDTH (CYCLE_WIDTH)
  ) u_serializer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (capture),
    .results_i   (core_results),
    .count_i     (cycle_cnt_q),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .frame_done_o(frame_done)
  );

  assign core_rst      = core_rst_q;
  assign busy          = (state_q != ST_IDLE);
  assign cycle_count   = cycle_cnt_q;
  assign results_valid = results_valid_q;
  assign timed_out     = timed_out_q;

endmodule

// File: tb/tb_puzzle_run_controller.sv
// Randomised bench for puzzle_run_controller: two instances (no timeout and
// TIMEOUT=50) checked against a frame/count model built from the run rules.
module tb_puzzle_run_controller;
  import puzzle_run_pkg::*;

  localparam int NR = 2;
  localparam int RW = 64;
  localparam int CW = 32;
  localparam int RH = 5;
  localparam int SC = 5;
  localparam int B  = frame_bytes(NR, RW, CW);

  logic clk = 1'b0;
  logic rst_n;
  logic             start_s[2], core_done_s[2], out_ready_s[2];
  logic [NR*RW-1:0] core_results_s[2];
  logic             core_rst_s[2], busy_s[2], results_valid_s[2], timed_out_s[2];
  logic             out_valid_s[2], out_last_s[2];
  logic [CW-1:0]    cycle_count_s[2];
  logic [7:0]       out_data_s[2];

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] want_bytes[B];

  always #5 clk = ~clk;

  puzzle_run_controller #(
    .N_RESULTS(NR), .RESULT_WIDTH(RW), .CYCLE_WIDTH(CW),
    .RESET_HOLD(RH), .SETTLE_CYCLES(SC), .TIMEOUT(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .core_rst(core_rst_s[0]),
    .core_done(core_done_s[0]), .core_results(core_results_s[0]), .busy(busy_s[0]),
    .cycle_count(cycle_count_s[0]), .results_valid(results_valid_s[0]),
    .timed_out(timed_out_s[0]), .out_data(out_data_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .out_last(out_last_s[0])
  );

  puzzle_run_controller #(
    .N_RESULTS(NR), .RESULT_WIDTH(RW), .CYCLE_WIDTH(CW),
    .RESET_HOLD(RH), .SETTLE_CYCLES(SC), .TIMEOUT(50)
  ) u_dut_to (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .core_rst(core_rst_s[1]),
    .core_done(core_done_s[1]), .core_results(core_results_s[1]), .busy(busy_s[1]),
    .cycle_count(cycle_count_s[1]), .results_valid(results_valid_s[1]),
    .timed_out(timed_out_s[1]), .out_data(out_data_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .out_last(out_last_s[1])
  );

  function automatic int timeout_of(input int sel);
    return (sel == 1) ? 50 : 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic check_reset_vals(input int sel, input string tag);
    check({tag, " core_rst"},      core_rst_s[sel],      1);
    check({tag, " busy"},          busy_s[sel],          0);
    check({tag, " cycle_count"},   cycle_count_s[sel],   0);
    check({tag, " results_valid"}, results_valid_s[sel], 0);
    check({tag, " timed_out"},     timed_out_s[sel],     0);
    check({tag, " out_valid"},     out_valid_s[sel],     0);
    check({tag, " out_data"},      out_data_s[sel],      0);
    check({tag, " out_last"},      out_last_s[sel],      0);
  endtask

  // Frame model: each result word then the count, each LSB-first.
  task automatic build_frame(input logic [63:0] r0, input logic [63:0] r1,
                             input logic [31:0] cnt);
    for (int b = 0; b < 8; b++) begin
      want_bytes[b]     = 8'(r0 >> (8 * b));
      want_bytes[8 + b] = 8'(r1 >> (8 * b));
    end
    for (int b = 0; b < 4; b++) want_bytes[16 + b] = 8'(cnt >> (8 * b));
  endtask

  task automatic do_run(input int sel, input logic [63:0] r0, input logic [63:0] r1,
                        input int delay, input int ready_mode, input bit poke_run,
                        input bit poke_stream, input string name);
    int  tmo      = timeout_of(sel);
    bit  hit      = (tmo != 0) && (delay >= tmo);
    int  want_cnt = hit ? tmo : delay;
    int  hold, waited, guard, idx;
    bit  ready, prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    @(negedge clk);
    core_results_s[sel] = {r1, r0};
    core_done_s[sel]    = 1'b0;
    out_ready_s[sel]    = 1'b0;
    start_s[sel]        = 1'b1;
    @(negedge clk);
    start_s[sel] = 1'b0;
    check({name, " busy_after_start"}, busy_s[sel], 1);
    check({name, " rv_cleared"}, results_valid_s[sel], 0);
    check({name, " count_cleared"}, cycle_count_s[sel], 0);
    check({name, " to_cleared"}, timed_out_s[sel], 0);

    hold = 0;
    while (core_rst_s[sel] && hold < 100) begin
      hold++;
      @(negedge clk);
    end
    check({name, " hold_cycles"}, hold, RH);

    waited = 0;
    while (!out_valid_s[sel] && waited < 1000) begin
      start_s[sel] = poke_run && (waited == 2);
      if (!hit && waited == delay) core_done_s[sel] = 1'b1;
      else if (!hit && waited == delay + 1 && (delay % 2 == 1)) core_done_s[sel] = 1'b0;
      @(negedge clk);
      waited++;
    end
    start_s[sel] = 1'b0;
    check({name, " valid_latency"}, waited, hit ? tmo + 1 : delay + SC + 2);
    check({name, " cycle_count"}, cycle_count_s[sel], want_cnt);
    check({name, " timed_out"}, timed_out_s[sel], hit);
    check({name, " results_valid"}, results_valid_s[sel], 1);

    build_frame(r0, r1, 32'(want_cnt));
    idx = 0;
    guard = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    while (idx < B && guard < 2000) begin
      start_s[sel] = poke_stream && (guard == 1);
      if (prev_stall)
        check($sformatf("%s stall_hold%0d", name, idx),
              {out_valid_s[sel], out_last_s[sel], out_data_s[sel]},
              {1'b1, prev_last, prev_data});
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = (guard % 3 == 2);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid_s[sel] && ready) begin
        check($sformatf("%s byte%0d", name, idx), out_data_s[sel], want_bytes[idx]);
        check($sformatf("%s last%0d", name, idx), out_last_s[sel], idx == B - 1);
        idx++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = out_valid_s[sel];
        prev_data  = out_data_s[sel];
        prev_last  = out_last_s[sel];
      end
      out_ready_s[sel] = ready;
      @(negedge clk);
      guard++;
    end
    start_s[sel]     = 1'b0;
    out_ready_s[sel] = 1'b0;
    core_done_s[sel] = 1'b0;
    check({name, " bytes_seen"}, idx, B);
    if (ready_mode == 0) check({name, " frame_cycles"}, guard, B);
    check({name, " busy_after"}, busy_s[sel], 0);
    check({name, " valid_after"}, out_valid_s[sel], 0);
    check({name, " core_rst_after"}, core_rst_s[sel], 1);
    check({name, " count_held"}, cycle_count_s[sel], want_cnt);
    check({name, " rv_held"}, results_valid_s[sel], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start_s[s] = 1'b0; core_done_s[s] = 1'b0; out_ready_s[s] = 1'b0;
      core_results_s[s] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals(0, "in_reset0");
    check_reset_vals(1, "in_reset1");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals(0, "post_reset");

    do_run(0, 64'h1122334455667788, 64'h5, 100, 0, 1'b0, 1'b0, "normal");
    do_run(0, 64'h1122334455667788, 64'h5, 100, 1, 1'b0, 1'b0, "backpressure");
    do_run(1, {$urandom, $urandom}, {$urandom, $urandom}, 999, 0, 1'b0, 1'b0, "timeout");
    do_run(0, {$urandom, $urandom}, {$urandom, $urandom}, 60, 2, 1'b1, 1'b1, "ignored_start");

    // Asynchronous reset in the middle of a run, then a clean run.
    @(negedge clk);
    core_results_s[0] = {$urandom, $urandom, $urandom, $urandom};
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    w = 0;
    while (cycle_count_s[0] != 40 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("arst reached_40", cycle_count_s[0], 40);
    #2 rst_n = 1'b0;
    #1 check_reset_vals(0, "arst_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    do_run(0, 64'h1122334455667788, 64'h5, 100, 0, 1'b0, 1'b0, "after_arst");

    for (int i = 0; i < 6; i++) begin
      do_run(i % 2, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 80)), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
